// File: rtl/piso_pkg.sv
//==============================================================================
// Module   : piso_pkg
// Brief    : Shared state encoding and sizing helper for the PISO serialiser.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Wide enough to hold 0..width, so the count never aliases at full frame.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_bitcnt.sv
//==============================================================================
// Module   : piso_bitcnt
// Brief    : Frame bit counter 0..WIDTH-1 with clear, enable and last-bit flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] c_last_val = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;

    assign last = (r_cnt == c_last_val);

    // Returning to zero on the last bit leaves the counter ready for the next frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso_stream.sv
//==============================================================================
// Module   : piso_stream
// Brief    : Parallel-in serial-out streamer with valid/ready on both sides.
//            Optional even-parity trailer bit enabled by PISO_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             empty,
    output logic             done
);

    localparam int c_cnt_w = cnt_width(WIDTH);

    piso_state_t      r_state;
    piso_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;
    logic             w_data_bit;
    logic             w_cnt_last;
    logic             w_bit_hs;
    logic             w_final;
    logic             w_load;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_data_bit = r_shift[WIDTH-1];
            assign w_shifted  = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_data_bit = r_shift[0];
            assign w_shifted  = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

`ifdef PISO_PARITY_EN
    logic r_parity;

    assign w_final = (r_state == PARITY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^p_in;
        end
    end
`else
    assign w_final = (r_state == SHIFT) && w_cnt_last;
`endif

    assign s_valid    = (r_state != IDLE);
    assign empty      = (r_state == IDLE);
    assign w_bit_hs   = s_valid && s_ready;
    // Accepting during the final consumed bit is what makes frames gap-free.
    assign load_ready = (r_state == IDLE) || (w_final && s_ready);
    assign done       = w_final && s_ready;
    assign w_load     = load_valid && load_ready;

    always_comb begin
        s_out = 1'b0;
        if (r_state == SHIFT) begin
            s_out = w_data_bit;
        end
`ifdef PISO_PARITY_EN
        else if (r_state == PARITY) begin
            s_out = r_parity;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_bit_hs && w_cnt_last) begin
`ifdef PISO_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = w_load ? SHIFT : IDLE;
`endif
                end
            end
            default: begin
                if (w_bit_hs) w_state_nxt = w_load ? SHIFT : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= p_in;
        end else if ((r_state == SHIFT) && w_bit_hs) begin
            r_shift <= w_shifted;
        end
    end

    piso_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (c_cnt_w)
    ) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   ((r_state == SHIFT) && w_bit_hs),
        .last (w_cnt_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
//==============================================================================
// Module   : tb_piso_stream
// Brief    : Scoreboard bench for piso_stream (WIDTH=4), MSB- and LSB-first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_piso_stream;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] p_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, s_out, s_valid, empty, done;
    logic         s_ready = 1'b1;

    logic [W-1:0] l_p_in = '0;
    logic         l_load_valid = 1'b0;
    logic         l_load_ready, l_s_out, l_s_valid, l_empty, l_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int l_done_cnt = 0;
    int run_len = 0;
    int max_run = 0;

    // Each entry is {done_expected_on_consume, bit}.
    logic [1:0] sb_q[$];
    logic [1:0] l_sb_q[$];

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(W), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .load_valid(load_valid),
        .load_ready(load_ready), .s_out(s_out), .s_valid(s_valid),
        .s_ready(s_ready), .empty(empty), .done(done)
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .p_in(l_p_in), .load_valid(l_load_valid),
        .load_ready(l_load_ready), .s_out(l_s_out), .s_valid(l_s_valid),
        .s_ready(1'b1), .empty(l_empty), .done(l_done)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w, input bit msb, inout logic [1:0] q[$]);
        for (int i = 0; i < W; i++) begin
            logic b;
            logic d;
            b = msb ? w[W-1-i] : w[i];
`ifdef PISO_PARITY_EN
            d = 1'b0;
`else
            d = (i == W - 1);
`endif
            q.push_back({d, b});
        end
`ifdef PISO_PARITY_EN
        q.push_back({1'b1, ^w});
`endif
    endtask

    // Main DUT monitor: compare consumed bits, then record any new load.
    always @(negedge clk) begin
        if (!rst) begin
            logic [1:0] e;
            check_value("s_valid", s_valid, sb_q.size() != 0);
            check_value("empty", empty, sb_q.size() == 0);
            if (s_valid && sb_q.size() != 0) begin
                e = sb_q[0];
                check_value("s_out", s_out, e[0]);
                check_value("done", done, s_ready & e[1]);
                check_value("load_ready", load_ready, s_ready & e[1]);
                if (s_ready) void'(sb_q.pop_front());
            end else if (!s_valid) begin
                check_value("idle_s_out", s_out, 1'b0);
                check_value("idle_done", done, 1'b0);
                check_value("idle_load_ready", load_ready, 1'b1);
            end
            if (done) done_cnt++;
            run_len = s_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (load_valid && load_ready) push_frame(p_in, 1'b1, sb_q);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [1:0] e;
            if (l_s_valid) begin
                if (l_sb_q.size() == 0) begin
                    check_value("lsb_unexpected_bit", 1, 0);
                end else begin
                    e = l_sb_q.pop_front();
                    check_value("lsb_s_out", l_s_out, e[0]);
                    check_value("lsb_done", l_done, e[1]);
                end
            end
            if (l_done) l_done_cnt++;
            if (l_load_valid && l_load_ready) push_frame(l_p_in, 1'b0, l_sb_q);
        end
    end

    task automatic load_word(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        load_valid = 1'b1;
        p_in = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_value("load_timeout", ok, 1'b1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        p_in = '0;
        check_value("latency_s_valid", s_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (empty && l_empty) begin
                ok = 1'b1;
                break;
            end
        end
        check_value(tag, ok, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_value("rst_empty", empty, 1'b1);
        check_value("rst_s_valid", s_valid, 1'b0);
        check_value("rst_load_ready", load_ready, 1'b1);
        check_value("rst_s_out", s_out, 1'b0);
        check_value("rst_done", done, 1'b0);

        // LSB-first instance: 1011 -> 1,1,0,1
        @(posedge clk); #1;
        l_load_valid = 1'b1;
        l_p_in = 4'b1011;
        @(posedge clk); #1;
        l_load_valid = 1'b0;
        l_p_in = '0;
        wait_idle("lsb_frame_timeout");
        check_value("lsb_done_count", l_done_cnt, 1);

        // Single MSB-first frame
        load_word(4'b1101);
        wait_idle("single_timeout");
        check_value("single_done_count", done_cnt, 1);

        // Back-to-back frames; second word is offered throughout the first
        max_run = 0;
        load_word(4'b1101);
        load_word(4'b1010);
        wait_idle("b2b_timeout");
        check_value("b2b_contiguous", max_run, 2 * FL);
        check_value("b2b_done_count", done_cnt, 3);

        // Downstream stall while the second bit (0) is presented
        load_word(4'b1011);
        @(posedge clk); #1;
        s_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_value("stall_s_out", s_out, 1'b0);
            check_value("stall_s_valid", s_valid, 1'b1);
            @(posedge clk); #1;
        end
        s_ready = 1'b1;
        wait_idle("stall_timeout");
        check_value("stall_done_count", done_cnt, 4);

        // Reset mid-frame after two bits
        load_word(4'b1101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_value("abort_empty", empty, 1'b1);
        check_value("abort_s_valid", s_valid, 1'b0);
        check_value("abort_no_done", done_cnt, 4);
        load_word(4'b0110);
        wait_idle("post_abort_timeout");
        check_value("final_done_count", done_cnt, 5);
        check_value("sb_drained", sb_q.size(), 0);
        check_value("lsb_sb_drained", l_sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 = serialise bit WIDTH-1 first, 0 = serialise bit 0 first.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p_in  input  WIDTH  parallel word to serialise.
REQ-006 load_valid  input  1  p_in holds a word offered for loading.
REQ-007 load_ready  output  1  block accepts p_in this cycle.
REQ-008 s_out  output  1  current serial bit.
REQ-009 s_valid  output  1  s_out holds a valid bit.
REQ-010 s_ready  input  1  downstream consumes s_out this cycle.
REQ-011 empty  output  1  no word loaded and no bit pending.
REQ-012 done  output  1  one-cycle pulse on the cycle the final bit of a frame is consumed.

Function
REQ-013 Load handshake SHALL complete on a rising edge where load_valid && load_ready; p_in is captured into the shift register at that edge.
REQ-014 Bit handshake SHALL complete on a rising edge where s_valid && s_ready; only then does the next bit advance.
REQ-015 FSM states SHALL be IDLE and SHIFT (plus PARITY, see REQ-027).
- IDLE -> SHIFT on load handshake.
- SHIFT -> IDLE on the final bit handshake with no simultaneous load.
- SHIFT -> SHIFT (new frame) on the final bit handshake with a simultaneous load.
REQ-016 load_ready SHALL be 1 in IDLE, and in SHIFT only on the final-bit cycle when s_ready=1, giving gap-free back-to-back frames.
REQ-017 Latency: first bit of a word loaded at edge N SHALL be on s_out with s_valid=1 in the cycle after edge N.
REQ-018 With s_ready held at 1, a WIDTH-bit frame SHALL occupy exactly WIDTH consecutive cycles of s_valid.
REQ-019 With s_ready=0, s_out, s_valid, bit counter and shift register SHALL hold unchanged.
REQ-020 Bit counter SHALL be $clog2(WIDTH+1) bits and count 0..WIDTH-1; it SHALL never wrap mid-frame.
REQ-021 done SHALL assert for exactly one cycle, coincident with the final bit handshake.
REQ-022 empty SHALL equal (state == IDLE); s_valid SHALL equal !empty.
REQ-023 load_valid in SHIFT outside the final-bit cycle SHALL be ignored; no word corruption, and p_in need not be held.
REQ-024 In IDLE, s_out SHALL be 0.

Reset
REQ-025 While rst=1 at a rising edge: state=IDLE, counter=0, shift register=0, s_out=0, s_valid=0, done=0, empty=1, load_ready=1 in the following cycle.
REQ-026 rst mid-frame SHALL abort the frame immediately; remaining bits are discarded and no done pulse is generated; rst overrides a simultaneous load.

Configuration
REQ-027 With PISO_PARITY_EN defined, a PARITY state SHALL follow the last data bit. In it, s_out = XOR of the loaded word (even parity), it uses the same s_ready handshake, and done/load_ready move to this cycle, making the frame WIDTH+1 bits. Without PISO_PARITY_EN, the PARITY state, its logic and the parity register SHALL be absent and the frame is WIDTH bits.

Structure
REQ-028 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and a constant function for counter width.
REQ-029 One sub-module, piso_bitcnt, SHALL implement the bit counter with clear, enable and last-bit flag; everything else stays in piso_stream.

Verification
REQ-030 Bench parameters WIDTH=4, MSB_FIRST=1, s_ready=1, load 4'b1101: s_out = 1,1,0,1 over 4 consecutive cycles; done pulses on the 4th cycle; empty=1 afterwards.
REQ-031 MSB_FIRST=0, load 4'b1011: s_out = 1,1,0,1 (LSB first).
REQ-032 Back-to-back loads 4'b1101 then 4'b1010 (second offered during the final bit): 8 contiguous s_valid cycles with s_out = 1,1,0,1,1,0,1,0, and two done pulses.
REQ-033 Load 4'b1011, s_ready=0 for 3 cycles after the 2nd bit: s_out holds 0 for those 3 cycles, then the sequence resumes 1,1 and the frame completes.
REQ-034 Load 4'b1101, assert rst after 2 bits: empty=1 and s_valid=0 the next cycle, no done pulse; a following load of 4'b0110 serialises 0,1,1,0 correctly.
REQ-035 With PISO_PARITY_EN defined, load 4'b1101: s_out = 1,1,0,1,1 (parity 1); done on the 5th bit; load_ready only on the 5th cycle.
